bsg_acm_encryptor: RTL and testbench

- Encrypt-side counterpart of the Arnold's Cat Map decryptor cell array.
- Accepts an N_p x N_p binary image one row per beat and latches an iteration count.
- Applies the forward cat-map permutation (x,y) -> ((x+y) mod N_p, (x+2y) mod N_p) that many times, one whole-image iteration per cycle.
- Streams the scrambled image out row by row over a valid/ready handshake, so the decryptor side receives exactly this block's output.

---
 rtl/bsg_acm_encryptor.sv | 90 +++++++++
 tb/tb_bsg_acm_encryptor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_acm_encryptor.sv
// rtl/bsg_acm_encryptor.sv - Arnold's Cat Map image scrambler
// Loads an N_p x N_p binary image row by row, applies the forward cat map iters times, streams it out.
module bsg_acm_encryptor #(
  parameter int N_p          = 8,
  parameter int iter_width_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [N_p-1:0]          data_i,
  input  logic [iter_width_p-1:0] iters_i,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic [N_p-1:0]          data_o,
  output logic                    busy_o
);

  localparam int lg_n_lp = $clog2(N_p);

  localparam logic [1:0] load_s    = 2'd0;
  localparam logic [1:0] permute_s = 2'd1;
  localparam logic [1:0] unload_s  = 2'd2;

  logic [1:0]                    state_r;
  logic [lg_n_lp-1:0]            cnt_r;
  logic [iter_width_p-1:0]       iter_r;
  logic [N_p-1:0][N_p-1:0]       img_r;
  logic [N_p-1:0][N_p-1:0]       img_n;
  logic                          last_row;

  // N_p is a power of two, so the last row index is all ones and cnt_r wraps to 0 by itself.
  assign last_row = (cnt_r == {lg_n_lp{1'b1}});

  // One full cat-map step is pure wiring: pixel (x,y) moves to ((x+y), (x+2y)) mod N_p.
  for (genvar y = 0; y < N_p; y++) begin : g_row
    for (genvar x = 0; x < N_p; x++) begin : g_col
      localparam int xp_lp = (x + y) % N_p;
      localparam int yp_lp = (x + 2 * y) % N_p;
      assign img_n[yp_lp][xp_lp] = img_r[y][x];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= load_s;
      cnt_r   <= '0;
      iter_r  <= '0;
      img_r   <= '0;
    end else begin
      case (state_r)
        load_s: begin
          if (v_i) begin
            img_r[cnt_r] <= data_i;
            cnt_r        <= cnt_r + 1'b1;
            if (cnt_r == '0) begin
              iter_r <= iters_i;
            end
            // iter_r was captured on row 0, which always precedes the last row.
            if (last_row) begin
              state_r <= (iter_r == '0) ? unload_s : permute_s;
            end
          end
        end
        permute_s: begin
          img_r  <= img_n;
          iter_r <= iter_r - 1'b1;
          if (iter_r == iter_width_p'(1)) begin
            state_r <= unload_s;
          end
        end
        unload_s: begin
          if (ready_i) begin
            cnt_r <= cnt_r + 1'b1;
            if (last_row) begin
              state_r <= load_s;
            end
          end
        end
        default: state_r <= load_s;
      endcase
    end
  end

  assign ready_o = (state_r == load_s);
  assign v_o     = (state_r == unload_s);
  assign busy_o  = (state_r != load_s);
  assign data_o  = v_o ? img_r[cnt_r] : '0;

endmodule

// File: tb/tb_bsg_acm_encryptor.sv
// tb/tb_bsg_acm_encryptor.sv - randomized bench for bsg_acm_encryptor
// Drives N_p=4 and N_p=8 instances, compares against a pixel-level cat-map model.
module tb_bsg_acm_encryptor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       v_i;
  logic       ready_i;
  logic [7:0] data_i;
  logic [3:0] iters_i;
  logic       sel4;

  logic       ready4, vo4, busy4;
  logic [3:0] data4;
  logic       ready8, vo8, busy8;
  logic [7:0] data8;

  logic       rdy, vo, busy;
  logic [7:0] dout;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_img [8];
  logic [7:0] exp_img [8];

  always #5 clk = ~clk;

  bsg_acm_encryptor #(.N_p(4), .iter_width_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i & sel4), .ready_o(ready4),
    .data_i(data_i[3:0]), .iters_i(iters_i), .v_o(vo4), .ready_i(ready_i),
    .data_o(data4), .busy_o(busy4)
  );

  bsg_acm_encryptor #(.N_p(8), .iter_width_p(4)) dut8 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i & ~sel4), .ready_o(ready8),
    .data_i(data_i), .iters_i(iters_i), .v_o(vo8), .ready_i(ready_i),
    .data_o(data8), .busy_o(busy8)
  );

  assign rdy  = sel4 ? ready4 : ready8;
  assign vo   = sel4 ? vo4 : vo8;
  assign busy = sel4 ? busy4 : busy8;
  assign dout = sel4 ? {4'b0, data4} : data8;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // Move every set pixel to its cat-map destination, k times over.
  function automatic void model(input int n, input int k);
    logic [7:0] cur [8];
    logic [7:0] nxt [8];
    for (int y = 0; y < 8; y++) cur[y] = src_img[y];
    for (int it = 0; it < k; it++) begin
      for (int y = 0; y < 8; y++) nxt[y] = 8'h00;
      for (int y = 0; y < n; y++)
        for (int x = 0; x < n; x++)
          nxt[(x + 2 * y) % n][(x + y) % n] = cur[y][x];
      cur = nxt;
    end
    for (int y = 0; y < 8; y++) exp_img[y] = cur[y];
  endfunction

  function automatic void rand_img(input int n);
    for (int y = 0; y < 8; y++)
      src_img[y] = (y < n) ? 8'($urandom & ((1 << n) - 1)) : 8'h00;
  endfunction

  function automatic void pixel_img(input int x, input int y);
    for (int r = 0; r < 8; r++) src_img[r] = 8'h00;
    src_img[y][x] = 1'b1;
  endfunction

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk({tag, "_ready"}, rdy, 1);
    chk({tag, "_vo"}, vo, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data"}, dout, 0);
  endtask

  // Called at a negedge; returns at the negedge just after the last input beat.
  task automatic send_image(input int n, input int k, input bit gaps);
    for (int y = 0; y < n; y++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          v_i = 1'b0;
          data_i = 8'($urandom);
          iters_i = 4'($urandom);
          @(posedge clk);
          @(negedge clk);
        end
      end
      v_i = 1'b1;
      data_i = src_img[y] | (sel4 ? 8'($urandom & 8'hf0) : 8'h00);
      iters_i = (y == 0) ? 4'(k) : 4'($urandom);
      chk("load_ready", rdy, 1);
      @(posedge clk);
      @(negedge clk);
    end
    v_i = 1'b0;
  endtask

  task automatic recv_image(input int n, input int k, input bit stall, input bit vhold);
    int lat;
    logic [7:0] held;
    lat = 1;
    if (vhold) v_i = 1'b1;
    while (!vo && lat <= 40) begin
      data_i = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, k + 1);
    if (!vo) begin
      v_i = 1'b0;
      return;
    end
    for (int y = 0; y < n; y++) begin
      data_i = 8'($urandom);
      chk("out_v", vo, 1);
      chk($sformatf("out_row%0d", y), dout, exp_img[y]);
      chk("unload_ready", rdy, 0);
      chk("unload_busy", busy, 1);
      if (stall && y == 2) begin
        held = dout;
        ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk);
          @(negedge clk);
          chk("stall_v", vo, 1);
          chk("stall_data", dout, held);
        end
      end
      ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready_i = 1'b0;
    end
    v_i = 1'b0;
    chk("after_ready", rdy, 1);
    chk("after_vo", vo, 0);
    chk("after_busy", busy, 0);
  endtask

  task automatic run(input int n, input int k, input bit gaps, input bit stall, input bit vhold);
    sel4 = (n == 4);
    model(n, k);
    send_image(n, k, gaps);
    recv_image(n, k, stall, vhold);
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    v_i = 1'b0;
    ready_i = 1'b0;
    data_i = '0;
    iters_i = '0;
    sel4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_ready4", ready4, 1);
    chk("rst_vo4", vo4, 0);
    chk("rst_ready8", ready8, 1);
    chk("rst_busy8", busy8, 0);
    chk("rst_data8", data8, 0);

    pixel_img(1, 0); run(4, 1, 0, 0, 0);
    pixel_img(0, 1); run(4, 1, 0, 0, 0);
    pixel_img(0, 0); run(4, 7, 0, 0, 0);
    rand_img(4);     run(4, 3, 1, 0, 0);
    rand_img(4);     run(4, 0, 0, 0, 0);

    rand_img(8);     run(8, 6, 1, 0, 0);
    rand_img(8);     run(8, 5, 1, 1, 1);
    rand_img(8);     run(8, 15, 1, 0, 1);

    // Abort mid-permute.
    sel4 = 1'b0;
    rand_img(8);
    send_image(8, 15, 0);
    repeat (3) @(negedge clk);
    chk("mid_perm_busy", busy, 1);
    do_reset("rst_perm");

    // Abort mid-unload after two rows have left.
    rand_img(8);
    send_image(8, 2, 0);
    lat = 0;
    while (!vo && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("pre_unload_v", vo, 1);
    for (int r = 0; r < 2; r++) begin
      ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    ready_i = 1'b0;
    do_reset("rst_unload");

    rand_img(8);     run(8, 4, 1, 0, 0);
    rand_img(4);     run(4, 2, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = ($urandom_range(0, 1) == 0) ? 4 : 8;
      rand_img(n);
      run(n, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
